// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: imem request/response plus the decode handshake and PC-mux feedback.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic [ADDR_W-1:0] next_pc;
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic [ADDR_W-1:0] instr_pc_plus4;
   logic              fetch_fault;

   modport master (
      input  next_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
      output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
             fetch_fault
   );

   modport slave (
      output next_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
      input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
             fetch_fault
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps at most one imem request in flight and holds
// each fetched instruction for decode; a misaligned next-PC parks the unit in a sticky fault.
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                clk,
   input logic                rst_n,
   instr_fetch_unit_if.master io_bus
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFault} state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_instr_pc;
   logic [31:0]       r_instr;
   logic              r_fault;
   logic              w_rsp_take;
   logic              w_pc_load;
   logic              w_fault_set;
   logic              w_target_ok;

   assign w_target_ok = (io_bus.next_pc[1:0] == 2'b00);

   always_comb begin
      w_state_d   = r_state;
      w_rsp_take  = 1'b0;
      w_pc_load   = 1'b0;
      w_fault_set = 1'b0;
      unique case (r_state)
         StIdle:  w_state_d = StReq;
         StReq:   if (io_bus.imem_req_ready) w_state_d = StWait;
         StWait: begin
            if (io_bus.imem_rsp_valid) begin
               w_rsp_take = 1'b1;
               w_state_d  = StHold;
            end
         end
         StHold: begin
            // next_pc is only meaningful on the decode handshake
            if (io_bus.instr_ready) begin
               if (w_target_ok) begin
                  w_pc_load = 1'b1;
                  w_state_d = StReq;
               end else begin
                  w_fault_set = 1'b1;
                  w_state_d   = StFault;
               end
            end
         end
         StFault: w_state_d = StFault;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_fault    <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (w_pc_load) r_pc <= io_bus.next_pc;
         if (w_rsp_take) begin
            r_instr    <= io_bus.imem_rsp_data;
            r_instr_pc <= r_pc;
         end
         if (w_fault_set) r_fault <= 1'b1;
      end
   end

   assign io_bus.imem_req_valid = (r_state == StReq);
   assign io_bus.imem_req_addr  = r_pc;
   assign io_bus.instr_valid    = (r_state == StHold);
   assign io_bus.instr          = r_instr;
   assign io_bus.instr_pc       = r_instr_pc;
   // Wraps modulo 2^ADDR_W by construction
   assign io_bus.instr_pc_plus4 = r_instr_pc + ADDR_W'(4);
   assign io_bus.fetch_fault    = r_fault;

endmodule
